alu_issue: RTL and testbench

- Execute-stage issue/capture unit. It is the initiator side of the ALU operand/result interface.
- Accepts one decoded instruction per valid/ready handshake and drives the ALU operand and function ports.
- Holds those ports stable while the ALU reports busy (shifter or mul/div multi-cycle ops), then registers the result.
- Presents the result to writeback on a valid/ready handshake.

---
 rtl/alu_issue.sv | 177 +++++++++++++++++
 tb/tb_alu_issue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Execute-stage issue/capture unit: decodes one instruction, drives the ALU ports,
// waits out ALU busy cycles, then presents the captured result to writeback.
module alu_issue #(
  parameter int MAX_BUSY = 64,
  parameter int CNT_W    = 7
) (
  input  logic        i_clk_n,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_flush,
  output logic [31:0] o_in_a,
  output logic [31:0] o_in_b,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic        o_alu_en,
  output logic        o_alu_imm,
  input  logic        i_alu_busy,
  input  logic [31:0] i_alu_out,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_res_data,
  output logic [4:0]  o_res_rd,
  output logic [1:0]  o_res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BUSY);

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] busy_cnt_inc;

  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_f3;
  logic [6:0]  dec_f7;
  logic        dec_en;
  logic        dec_imm;
  logic        dec_legal;

  assign imm_i        = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_u        = {i_instr[31:12], 12'b0};
  assign busy_cnt_inc = busy_cnt + CNT_W'(1);

  always_comb begin
    dec_a     = '0;
    dec_b     = '0;
    dec_f3    = '0;
    dec_f7    = '0;
    dec_en    = 1'b0;
    dec_imm   = 1'b0;
    dec_legal = 1'b0;
    case (i_instr[6:0])
      OPC_OP: begin
        dec_a     = i_rs1;
        dec_b     = i_rs2;
        dec_f3    = i_instr[14:12];
        dec_f7    = i_instr[31:25];
        dec_en    = 1'b1;
        dec_legal = 1'b1;
      end
      OPC_IMM: begin
        dec_a     = i_rs1;
        dec_b     = imm_i;
        dec_f3    = i_instr[14:12];
        // funct7 only qualifies the shift-immediate forms
        if (i_instr[13:12] == 2'b01) dec_f7 = i_instr[31:25];
        dec_en    = 1'b1;
        dec_imm   = 1'b1;
        dec_legal = 1'b1;
      end
      OPC_LUI: begin
        dec_b     = imm_u;
        dec_imm   = 1'b1;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a     = i_pc;
        dec_b     = imm_u;
        dec_imm   = 1'b1;
        dec_legal = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk_n or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      busy_cnt    <= '0;
      o_req_ready <= 1'b1;
      o_in_a      <= '0;
      o_in_b      <= '0;
      o_funct3    <= '0;
      o_funct7    <= '0;
      o_alu_en    <= 1'b0;
      o_alu_imm   <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_rd    <= '0;
      o_res_err   <= '0;
    end else if (i_flush) begin
      state       <= IDLE;
      busy_cnt    <= '0;
      o_req_ready <= 1'b1;
      o_in_a      <= '0;
      o_in_b      <= '0;
      o_funct3    <= '0;
      o_funct7    <= '0;
      o_alu_en    <= 1'b0;
      o_alu_imm   <= 1'b0;
      o_res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            o_res_rd    <= i_instr[11:7];
            busy_cnt    <= '0;
            if (dec_legal) begin
              o_in_a    <= dec_a;
              o_in_b    <= dec_b;
              o_funct3  <= dec_f3;
              o_funct7  <= dec_f7;
              o_alu_en  <= dec_en;
              o_alu_imm <= dec_imm;
              state     <= EXEC;
            end else begin
              o_res_data  <= '0;
              o_res_err   <= 2'b01;
              o_res_valid <= 1'b1;
              state       <= DONE;
            end
          end
        end
        EXEC: begin
          if (!i_alu_busy || busy_cnt_inc == CNT_LIMIT) begin
            // a busy ALU reaching the limit completes as a timeout
            o_res_data  <= i_alu_busy ? 32'd0 : i_alu_out;
            o_res_err   <= i_alu_busy ? 2'b10 : 2'b00;
            o_res_valid <= 1'b1;
            o_in_a      <= '0;
            o_in_b      <= '0;
            o_funct3    <= '0;
            o_funct7    <= '0;
            o_alu_en    <= 1'b0;
            o_alu_imm   <= 1'b0;
            state       <= DONE;
          end else begin
            busy_cnt <= busy_cnt_inc;
          end
        end
        DONE: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed plan cases plus random instructions
// checked against an instruction-level reference model.
module tb_alu_issue;
  localparam int MAX_BUSY = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alu_en;
  logic        alu_imm;
  logic        alu_busy = 1'b0;
  logic [31:0] alu_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic [1:0]  res_err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_issue #(.MAX_BUSY(MAX_BUSY), .CNT_W(7)) dut (
    .i_clk_n(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_instr(instr), .i_pc(pc), .i_rs1(rs1), .i_rs2(rs2), .i_flush(flush),
    .o_in_a(in_a), .o_in_b(in_b), .o_funct3(funct3), .o_funct7(funct7),
    .o_alu_en(alu_en), .o_alu_imm(alu_imm),
    .i_alu_busy(alu_busy), .i_alu_out(alu_out),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_rd(res_rd), .o_res_err(res_err)
  );

  // Environment ALU: responds combinationally to whatever the DUT drives
  logic signed [31:0] sa;
  always_comb begin
    alu_out = '0;
    sa = $signed(in_a);
    case (funct3)
      3'd0: alu_out = (funct7[5] && !alu_imm) ? in_a - in_b : in_a + in_b;
      3'd1: alu_out = in_a << in_b[4:0];
      3'd2: alu_out = ($signed(in_a) < $signed(in_b)) ? 32'd1 : 32'd0;
      3'd3: alu_out = (in_a < in_b) ? 32'd1 : 32'd0;
      3'd4: alu_out = in_a ^ in_b;
      3'd5: begin
        if (funct7[5]) alu_out = sa >>> in_b[4:0];
        else           alu_out = in_a >> in_b[4:0];
      end
      3'd6: alu_out = in_a | in_b;
      default: alu_out = in_a & in_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] opc);
    return opc == 7'b0110011 || opc == 7'b0010011 || opc == 7'b0110111 || opc == 7'b0010111;
  endfunction

  // Architectural result of the instruction (RV32I semantics)
  function automatic logic [31:0] ref_result(input logic [31:0] ins, input logic [31:0] pc_v,
                                              input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] opnd;
    logic signed [31:0] s1;
    logic alt;
    alt = ins[30];
    s1 = $signed(r1);
    if (ins[6:0] == 7'b0110111) return {ins[31:12], 12'b0};
    if (ins[6:0] == 7'b0010111) return pc_v + {ins[31:12], 12'b0};
    if (ins[6:0] == 7'b0110011) opnd = r2;
    else begin
      opnd = {{20{ins[31]}}, ins[31:20]};
      if (ins[14:12] == 3'd0) alt = 1'b0;
    end
    case (ins[14:12])
      3'd0: return alt ? r1 - opnd : r1 + opnd;
      3'd1: return r1 << opnd[4:0];
      3'd2: return ($signed(r1) < $signed(opnd)) ? 32'd1 : 32'd0;
      3'd3: return (r1 < opnd) ? 32'd1 : 32'd0;
      3'd4: return r1 ^ opnd;
      3'd5: begin
        if (alt) return s1 >>> opnd[4:0];
        return r1 >> opnd[4:0];
      end
      3'd6: return r1 | opnd;
      default: return r1 & opnd;
    endcase
  endfunction

  // Expected ALU port values for an accepted instruction
  task automatic port_ref(input logic [31:0] ins, input logic [31:0] pc_v, input logic [31:0] r1,
                          input logic [31:0] r2, output logic [31:0] ea, output logic [31:0] eb,
                          output logic [2:0] ef3, output logic [6:0] ef7, output logic een,
                          output logic eimm);
    ea = 0; eb = 0; ef3 = 0; ef7 = 0; een = 0; eimm = 0;
    case (ins[6:0])
      7'b0110011: begin ea = r1; eb = r2; ef3 = ins[14:12]; ef7 = ins[31:25]; een = 1; end
      7'b0010011: begin
        ea = r1; eb = {{20{ins[31]}}, ins[31:20]}; ef3 = ins[14:12]; een = 1; eimm = 1;
        if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ef7 = ins[31:25];
      end
      7'b0110111: begin eb = {ins[31:12], 12'b0}; eimm = 1; end
      7'b0010111: begin ea = pc_v; eb = {ins[31:12], 12'b0}; eimm = 1; end
      default: ;
    endcase
  endtask

  task automatic check_ports(input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] ef3,
                             input logic [6:0] ef7, input logic een, input logic eimm);
    check("in_a", in_a, ea);
    check("in_b", in_b, eb);
    check("funct3", 32'(funct3), 32'(ef3));
    check("funct7", 32'(funct7), 32'(ef7));
    check("alu_en", 32'(alu_en), 32'(een));
    check("alu_imm", 32'(alu_imm), 32'(eimm));
  endtask

  // One full transaction: accept, nbusy ALU busy cycles, result held for stall cycles
  task automatic run_op(input logic [31:0] ins, input logic [31:0] pc_v, input logic [31:0] r1,
                        input logic [31:0] r2, input int nbusy, input int stall);
    logic [31:0] ea, eb, edata;
    logic [2:0]  ef3;
    logic [6:0]  ef7;
    logic        een, eimm, legal;
    logic [1:0]  eerr;
    int          nloop;
    port_ref(ins, pc_v, r1, r2, ea, eb, ef3, ef7, een, eimm);
    legal = is_legal(ins[6:0]);
    eerr  = !legal ? 2'b01 : (nbusy >= MAX_BUSY) ? 2'b10 : 2'b00;
    edata = (eerr == 2'b00) ? ref_result(ins, pc_v, r1, r2) : 32'd0;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; instr = ins; pc = pc_v; rs1 = r1; rs2 = r2;
    @(negedge clk);
    req_valid = 0; instr = $urandom; pc = $urandom; rs1 = $urandom; rs2 = $urandom;
    if (legal) begin
      check_ports(ea, eb, ef3, ef7, een, eimm);
      check("req_ready_exec", 32'(req_ready), 32'd0);
      check("res_valid_exec", 32'(res_valid), 32'd0);
      alu_busy = (nbusy > 0);
      nloop = (nbusy >= MAX_BUSY) ? MAX_BUSY - 1 : nbusy;
      for (int b = 1; b <= nloop; b++) begin
        @(negedge clk);
        check_ports(ea, eb, ef3, ef7, een, eimm);
        check("res_valid_busy", 32'(res_valid), 32'd0);
        alu_busy = (nbusy >= MAX_BUSY) || (b < nbusy);
      end
      @(negedge clk);
      alu_busy = 0;
    end
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_data", res_data, edata);
    check("res_rd", 32'(res_rd), 32'(ins[11:7]));
    check("res_err", 32'(res_err), 32'(eerr));
    check_ports(32'd0, 32'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("res_valid_stall", 32'(res_valid), 32'd1);
      check("res_data_stall", res_data, edata);
      check("res_err_stall", 32'(res_err), 32'(eerr));
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    check("res_valid_after", 32'(res_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
    $display("op instr=%h rd=%0d busy=%0d stall=%0d data=%h err=%0d",
             ins, ins[11:7], nbusy, stall, edata, eerr);
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc;
    int          kind;

    rst_n = 1;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_res_rd", 32'(res_rd), 32'd0);
    check_ports(32'd0, 32'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    rst_n = 1;

    // ADD x3 = 5 + 7
    run_op({7'b0, 5'd7, 5'd5, 3'b000, 5'd3, 7'b0110011}, 32'h0, 32'd5, 32'd7, 0, 0);
    // SRAI by 4, three busy cycles
    run_op({7'b0100000, 5'd4, 5'd1, 3'b101, 5'd2, 7'b0010011}, 32'h0, 32'h8000_0000, 32'h0, 3, 0);
    // ADDI -1 with upper bits set: funct7 must be zeroed
    run_op({12'hFFF, 5'd1, 3'b000, 5'd4, 7'b0010011}, 32'h0, 32'd10, 32'h0, 0, 0);
    // LUI, AUIPC
    run_op({20'h12345, 5'd5, 7'b0110111}, 32'h0, 32'h0, 32'h0, 0, 0);
    run_op({20'h12345, 5'd6, 7'b0010111}, 32'h100, 32'h0, 32'h0, 0, 0);
    // illegal opcode
    run_op({20'h0, 5'd9, 7'b0000011}, 32'h0, 32'h1, 32'h2, 0, 0);
    // busy boundary: 63 completes normally, 64 times out
    run_op({7'b0100000, 5'd7, 5'd5, 3'b000, 5'd11, 7'b0110011}, 32'h0, 32'd100, 32'd1, 63, 0);
    run_op({7'b0, 5'd7, 5'd5, 3'b000, 5'd12, 7'b0110011}, 32'h0, 32'd1, 32'd1, MAX_BUSY, 0);
    // result held with ready low for 5 cycles
    run_op({7'b0, 5'd7, 5'd5, 3'b110, 5'd13, 7'b0110011}, 32'h0, 32'hF0F0_0000, 32'h0000_0F0F, 1, 5);

    // flush while busy
    @(negedge clk);
    req_valid = 1; instr = {7'b0, 5'd7, 5'd5, 3'b000, 5'd3, 7'b0110011}; rs1 = 32'd1; rs2 = 32'd2;
    @(negedge clk);
    req_valid = 0; alu_busy = 1;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0; alu_busy = 0;
    check("flush_req_ready", 32'(req_ready), 32'd1);
    check("flush_res_valid", 32'(res_valid), 32'd0);
    check("flush_alu_en", 32'(alu_en), 32'd0);
    check("flush_in_a", in_a, 32'd0);
    @(negedge clk);
    check("flush_no_result", 32'(res_valid), 32'd0);
    $display("op flush during busy");

    // flush while result pending
    @(negedge clk);
    req_valid = 1; instr = {20'h0, 5'd8, 7'b1111111};
    @(negedge clk);
    req_valid = 0;
    check("flush_done_valid_pre", 32'(res_valid), 32'd1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_done_valid", 32'(res_valid), 32'd0);
    check("flush_done_ready", 32'(req_ready), 32'd1);
    $display("op flush in done");

    // async reset mid-EXEC
    @(negedge clk);
    req_valid = 1; instr = {7'b0, 5'd7, 5'd5, 3'b000, 5'd3, 7'b0110011};
    @(negedge clk);
    req_valid = 0; alu_busy = 1;
    #2 rst_n = 0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_alu_en", 32'(alu_en), 32'd0);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1; alu_busy = 0;
    @(negedge clk);
    check("arst_no_result", 32'(res_valid), 32'd0);
    $display("op async reset in exec");

    // random instructions
    for (int n = 0; n < 40; n++) begin
      ins  = $urandom;
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin ins[6:0] = 7'b0110011; ins[31:25] = {1'b0, ins[30], 5'b0}; end
        1: begin
          ins[6:0] = 7'b0010011;
          if (ins[14:12] == 3'd1) ins[31:25] = 7'b0;
          if (ins[14:12] == 3'd5) ins[31:25] = {1'b0, ins[30], 5'b0};
        end
        2: ins[6:0] = 7'b0110111;
        3: ins[6:0] = 7'b0010111;
        default: begin
          opc = 7'($urandom);
          while (is_legal(opc)) opc = 7'($urandom);
          ins[6:0] = opc;
        end
      endcase
      run_op(ins, $urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
